// File: rtl/plic_pkg.sv
// ============================================================================
// plic_pkg : constants and types shared by the PLIC gateway and PLIC core
// Revision : 1.0
// ============================================================================
`default_nettype none

package plic_pkg;

  localparam int PLIC_NUM_SRC = 128;
  localparam int PLIC_ID_W    = 7;

  typedef enum logic [0:0] {
    GW_IDLE = 1'b0,
    GW_BUSY = 1'b1
  } gw_state_t;

endpackage

`default_nettype wire

// File: rtl/plic_gateway_cell.sv
// ============================================================================
// plic_gateway_cell : one interrupt source (sync, edge detect, edge counter, FSM)
// Revision : 1.0
// ============================================================================
`default_nettype none

module plic_gateway_cell
  import plic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  input  logic edge_mode,
  input  logic int_end,
  output logic int_req,
  output logic src_busy
);

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_prev_q, lvl_prev_d;
  logic [EDGE_CNT_W-1:0]  cnt_q, cnt_d;
  gw_state_t              state_q, state_d;
  logic                   int_req_q, int_req_d;

  logic lvl;
  logic edge_det;
  logic cnt_nz;

  assign lvl      = sync_q[SYNC_STAGES-1];
  assign edge_det = lvl & ~lvl_prev_q;
  assign cnt_nz   = |cnt_q;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq};
    lvl_prev_d = lvl;
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_req_d  = 1'b0;

    case (state_q)
      GW_IDLE: begin
        if (!edge_mode) begin
          cnt_d = '0;
          if (lvl) begin
            int_req_d = 1'b1;
            state_d   = GW_BUSY;
          end
        end else if (edge_det || cnt_nz) begin
          int_req_d = 1'b1;
          state_d   = GW_BUSY;
          // A fresh edge replaces the stored one being consumed, so cnt holds.
          if (cnt_nz && !edge_det) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GW_BUSY: begin
        if (edge_mode && edge_det && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (int_end) begin
          state_d = GW_IDLE;
        end
      end
      default: begin
        state_d = GW_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
      state_q    <= GW_IDLE;
      int_req_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      lvl_prev_q <= lvl_prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      int_req_q  <= int_req_d;
    end
  end

  assign int_req  = int_req_q;
  assign src_busy = (state_q == GW_BUSY);

endmodule

`default_nettype wire

// File: rtl/plic_gateway.sv
// ============================================================================
// plic_gateway : per-source interrupt gateways feeding the PLIC core
// Revision : 1.0
// ============================================================================
`default_nettype none

module plic_gateway
  import plic_pkg::*;
#(
  parameter int NUM_SRC     = PLIC_NUM_SRC,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] src_edge_mode,
  input  logic [NUM_SRC-1:0] int_end,
  output logic [NUM_SRC-1:0] int_req,
  output logic               gateway_notif,
  output logic [NUM_SRC-1:0] src_busy
);

  // ID 0 is reserved and has no cell.
  assign int_req[0]  = 1'b0;
  assign src_busy[0] = 1'b0;

  logic unused_id0;
  assign unused_id0 = ^{irq_src[0], src_edge_mode[0], int_end[0]};

  generate
    for (genvar i = 1; i < NUM_SRC; i++) begin : g_cell
      plic_gateway_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_CNT_W  (EDGE_CNT_W)
      ) u_cell (
        .clk       (clk),
        .rstn      (rstn),
        .irq       (irq_src[i]),
        .edge_mode (src_edge_mode[i]),
        .int_end   (int_end[i]),
        .int_req   (int_req[i]),
        .src_busy  (src_busy[i])
      );
    end
  endgenerate

  // int_req bits are flop outputs, so notif lines up with them cycle-for-cycle.
  assign gateway_notif = |int_req;

endmodule

`default_nettype wire

// File: tb/tb_plic_gateway.sv
// ============================================================================
// tb_plic_gateway : directed vector table plus hand sequences for plic_gateway
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_plic_gateway;

  localparam int N = 128;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] irq_src;
  logic [N-1:0] src_edge_mode;
  logic [N-1:0] int_end;
  logic [N-1:0] int_req;
  logic         gateway_notif;
  logic [N-1:0] src_busy;

  plic_gateway #(
    .NUM_SRC     (N),
    .SYNC_STAGES (2),
    .EDGE_CNT_W  (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .irq_src       (irq_src),
    .src_edge_mode (src_edge_mode),
    .int_end       (int_end),
    .int_req       (int_req),
    .gateway_notif (gateway_notif),
    .src_busy      (src_busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int req_cnt [N];

  initial for (int i = 0; i < N; i++) req_cnt[i] = 0;

  // Pulse scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < N; i++) if (int_req[i]) req_cnt[i] = req_cnt[i] + 1;
    end
  end

  typedef struct {
    int   id;
    logic irq;
    logic iend;
    logic exp_req;
    logic exp_busy;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn    = 1'b0;
    irq_src = '0;
    int_end = '0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic add(input int id, input logic irq, input logic iend,
                     input logic er, input logic eb);
    vec_t v;
    v.id = id; v.irq = irq; v.iend = iend; v.exp_req = er; v.exp_busy = eb;
    tv.push_back(v);
  endtask

  task automatic run_vec(input int lo, input int hi, input string nm);
    logic [N-1:0] one;
    logic [N-1:0] er;
    logic [N-1:0] eb;
    one = 1;
    for (int i = lo; i < hi; i++) begin
      irq_src[tv[i].id] = tv[i].irq;
      int_end[tv[i].id] = tv[i].iend;
      tick();
      er = tv[i].exp_req  ? (one << tv[i].id) : '0;
      eb = tv[i].exp_busy ? (one << tv[i].id) : '0;
      chk($sformatf("%s_req[%0d]", nm, i - lo), int_req, er);
      chk($sformatf("%s_busy[%0d]", nm, i - lo), src_busy, eb);
      chk($sformatf("%s_notif[%0d]", nm, i - lo), {{(N-1){1'b0}}, gateway_notif},
          {{(N-1){1'b0}}, tv[i].exp_req});
    end
    int_end = '0;
  endtask

  task automatic pulse_edge(input int id);
    irq_src[id] = 1'b1;
    tick();
    irq_src[id] = 1'b0;
    tick();
  endtask

  task automatic pulse_end(input int id);
    int_end[id] = 1'b1;
    tick();
    int_end[id] = 1'b0;
  endtask

  task automatic wait_req(input int id, input int max_cyc, input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (int_req[id]) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, {{(N-1){1'b0}}, seen}, {{(N-1){1'b0}}, 1'b1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] all_src;
    logic [N-1:0] bit1;
    int base;
    int t2_lo, t2_hi, t5_hi;
    bit1    = 1;
    all_src = {{(N-1){1'b1}}, 1'b0};

    // Test 2 table: ID 5 level mode
    t2_lo = tv.size();
    add(5, 1, 0, 0, 0);
    add(5, 1, 0, 0, 0);
    add(5, 1, 0, 1, 1);
    for (int k = 0; k < 9; k++) add(5, 1, 0, 0, 1);
    add(5, 1, 1, 0, 0);
    add(5, 1, 0, 1, 1);
    add(5, 0, 0, 0, 1);
    add(5, 0, 1, 0, 0);
    add(5, 0, 0, 0, 0);
    add(5, 0, 0, 0, 0);
    t2_hi = tv.size();
    // Test 5 table: ID 7 edge mode, int_end coincident with a new edge
    add(7, 1, 0, 0, 0);
    add(7, 1, 0, 0, 0);
    add(7, 1, 0, 1, 1);
    add(7, 0, 0, 0, 1);
    add(7, 0, 0, 0, 1);
    add(7, 1, 0, 0, 1);
    add(7, 1, 0, 0, 1);
    add(7, 1, 1, 0, 0);
    add(7, 1, 0, 1, 1);
    add(7, 1, 0, 0, 1);
    add(7, 1, 1, 0, 0);
    add(7, 1, 0, 0, 0);
    add(7, 1, 0, 0, 0);
    t5_hi = tv.size();

    // Test 1: reset with all sources high, all level mode
    rstn          = 1'b0;
    irq_src       = '1;
    src_edge_mode = '0;
    int_end       = '0;
    tick();
    tick();
    tick();
    chk("t1_rst_req", int_req, '0);
    chk("t1_rst_notif", {{(N-1){1'b0}}, gateway_notif}, '0);
    chk("t1_rst_busy", src_busy, '0);
    rstn = 1'b1;
    tick();
    chk("t1_req_c1", int_req, '0);
    tick();
    chk("t1_req_c2", int_req, '0);
    tick();
    chk("t1_req_c3", int_req, all_src);
    chk("t1_notif_c3", {{(N-1){1'b0}}, gateway_notif}, bit1);
    chk("t1_busy_c3", src_busy, all_src);
    tick();
    chk("t1_req_c4", int_req, '0);
    chk("t1_busy_c4", src_busy, all_src);

    // Test 2
    src_edge_mode = '0;
    reset_dut();
    run_vec(t2_lo, t2_hi, "t2");

    // Test 5
    src_edge_mode = bit1 << 7;
    reset_dut();
    run_vec(t2_hi, t5_hi, "t5");

    // Test 3: ID 33, three edges queued while busy
    src_edge_mode = bit1 << 33;
    reset_dut();
    base = req_cnt[33];
    pulse_edge(33);
    wait_req(33, 4, "t3_first_req");
    for (int k = 0; k < 3; k++) pulse_edge(33);
    tick();
    tick();
    chk("t3_busy_hold", src_busy, bit1 << 33);
    chk("t3_cnt_hold", N'(req_cnt[33] - base), N'(1));
    for (int k = 0; k < 3; k++) begin
      pulse_end(33);
      chk($sformatf("t3_idle[%0d]", k), src_busy, '0);
      chk($sformatf("t3_noreq[%0d]", k), int_req, '0);
      tick();
      chk($sformatf("t3_rereq[%0d]", k), int_req, bit1 << 33);
    end
    pulse_end(33);
    for (int k = 0; k < 4; k++) tick();
    chk("t3_final_busy", src_busy, '0);
    chk("t3_total", N'(req_cnt[33] - base), N'(4));

    // Test 4: ID 40, 20 edges while busy saturate at 15
    src_edge_mode = bit1 << 40;
    reset_dut();
    base = req_cnt[40];
    pulse_edge(40);
    wait_req(40, 4, "t4_first_req");
    for (int k = 0; k < 20; k++) pulse_edge(40);
    tick();
    tick();
    for (int k = 0; k < 17; k++) begin
      pulse_end(40);
      tick();
      tick();
      tick();
    end
    chk("t4_final_busy", src_busy, '0);
    chk("t4_total", N'(req_cnt[40] - base), N'(16));

    // Test 6: async reset while IDs 2 and 9 busy
    src_edge_mode = '0;
    reset_dut();
    irq_src[2] = 1'b1;
    irq_src[9] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_busy", src_busy, (bit1 << 2) | (bit1 << 9));
    irq_src = '0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_busy_hold", src_busy, (bit1 << 2) | (bit1 << 9));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_busy", src_busy, '0);
    chk("t6_async_req", int_req, '0);
    tick();
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("t6_post_req[%0d]", k), int_req, '0);
      chk($sformatf("t6_post_busy[%0d]", k), src_busy, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
